// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8)/S-box helpers for the AES-128 round engine.
package aes_pkg;

    localparam int NR = 10;
    localparam int BW = 128;
    localparam int KW = BW * (NR + 1);
    localparam logic [3:0] NR_4 = 4'(NR);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_state_e;

    // Entry 0x00 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Out-of-range round numbers yield a zero key rather than an out-of-bounds slice.
    function automatic logic [BW-1:0] round_key(input logic [KW-1:0] keys, input logic [3:0] rnd);
        if (int'(rnd) > NR) begin
            return '0;
        end
        return keys[int'(rnd) * BW +: BW];
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [BW-1:0] state_in,
    input  logic [BW-1:0] round_key,
    input  logic          final_round,
    output logic [BW-1:0] state_out
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte i is row (i % 4), column (i / 4); byte 0 is the MSB.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(state_in[127 - 8 * i -: 8]);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[r + 4 * c] = sb[r + 4 * ((c + r) % 4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4 * c]     = xtime(sr[4 * c]) ^ xtime(sr[4 * c + 1]) ^ sr[4 * c + 1]
                          ^ sr[4 * c + 2] ^ sr[4 * c + 3];
            mc[4 * c + 1] = sr[4 * c] ^ xtime(sr[4 * c + 1]) ^ xtime(sr[4 * c + 2])
                          ^ sr[4 * c + 2] ^ sr[4 * c + 3];
            mc[4 * c + 2] = sr[4 * c] ^ sr[4 * c + 1] ^ xtime(sr[4 * c + 2])
                          ^ xtime(sr[4 * c + 3]) ^ sr[4 * c + 3];
            mc[4 * c + 3] = xtime(sr[4 * c]) ^ sr[4 * c] ^ sr[4 * c + 1]
                          ^ sr[4 * c + 2] ^ xtime(sr[4 * c + 3]);
        end
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            state_out[127 - 8 * i -: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[127 - 8 * i -: 8];
        end
    end

endmodule

// File: rtl/aes128_round_engine.sv
// Iterative AES-128 encryption engine, one round per clock, valid/ready on both sides.
// Define AES_ZEROIZE_EN to clear the state register on the output handshake.
//
// state    | meaning
// ST_IDLE  | waiting for a plaintext block, in_ready high
// ST_ROUND | applying rounds 1..NR, one per cycle
// ST_DONE  | ciphertext presented, waiting for out_ready
module aes128_round_engine
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] plaintext,
    input  logic [KW-1:0] key_array,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] ciphertext,
    output logic          busy
);

    aes_state_e    state_q, state_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [BW-1:0] st_q, st_d;
    logic [BW-1:0] round_out;

    aes_round u_round (
        .state_in   (st_q),
        .round_key  (round_key(key_array, rnd_q)),
        .final_round(rnd_q == NR_4),
        .state_out  (round_out)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    st_d    = plaintext ^ round_key(key_array, 4'd0);
                    rnd_d   = 4'd1;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (rnd_q > NR_4 || rnd_q == 4'd0) begin
                    rnd_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    st_d  = round_out;
                    rnd_d = rnd_q + 4'd1;
                    if (rnd_q == NR_4) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    rnd_d   = '0;
                    state_d = ST_IDLE;
`ifdef AES_ZEROIZE_EN
                    st_d    = '0;
`else
                    st_d    = st_q;
`endif
                end
            end
            default: begin
                rnd_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q == ST_ROUND) || (state_q == ST_DONE);
    assign ciphertext = st_q;

endmodule

// File: doc/aes128_round_engine.md
Name: aes128_round_engine

Overview:
- Iterative AES-128 encryption datapath. Consumes the 11 round keys from the combinational key expander and performs one round per clock.
- Sits directly downstream of the key expander: key_array in, ciphertext out. Uses valid/ready handshakes on both sides.
- Intended as the core datapath of the encryption top level.

Parameters:
- NR, 10, number of rounds; fixed for AES-128 and must not be overridden.
- KW, 1408, key_array width = 128*(NR+1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  plaintext presented.
- in_ready  output  1  engine can accept a block (high only in IDLE).
- plaintext  input  128  block; bits [127:120] = state byte 0; column-major per FIPS-197.
- key_array  input  1408  round key r occupies [128r+127:128r]; round 0 = cipher key; word w(4r) is the MSB word.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  consumer accepts ciphertext.
- ciphertext  output  128  result, same byte order as plaintext.
- busy  output  1  high in ROUND or DONE.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, round counter=0, state register=0.
  - Reset output values: in_ready=1, out_valid=0, ciphertext=0, busy=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state_reg <= plaintext ^ key_array[127:0]; rnd <= 1; go to ROUND.
  - Inputs ignored while in_valid=0.
- ROUND:
  - Each cycle: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ key_array[128*rnd +: 128]; rnd <= rnd+1.
  - When rnd==NR: MixColumns skipped (final round); go to DONE.
  - in_ready=0; in_valid ignored.
- DONE:
  - out_valid=1; ciphertext = state_reg, held stable while out_ready=0.
  - On out_ready: go to IDLE; out_valid drops next cycle.
  - No same-cycle re-accept; in_ready rises the cycle after the output handshake.
- Latency: accept on edge 0 → out_valid high after edge 10 (10 cycles). Throughput: one block per 12 cycles minimum.
- key_array is not registered. The upstream side must hold key_array stable from the accept edge until the output handshake; a key change mid-operation gives undefined ciphertext, with no protocol error.
- rnd is 4 bits; values 11–15 are unreachable, and the FSM returns to IDLE if one is ever observed.
- Reset asserted mid-operation aborts immediately: outputs return to reset values and no partial result is presented.
- ciphertext is driven from state_reg in all states; it is meaningful only while out_valid=1.
- GF(2^8) arithmetic: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).

Optional Feature:
- Macro: AES_ZEROIZE_EN.
- Defined: on the output handshake (DONE && out_ready), state_reg <= 0 in the same edge. ciphertext therefore reads 0 in IDLE, so no residual cipher state remains.
- Undefined: state_reg retains the last ciphertext until the next accept.
- Handshake timing is identical in both builds.

Decomposition:
- Package aes_pkg:
  - NR, block width and key width constants.
  - FSM state enum.
  - S-box lookup function (256-entry constant table), xtime function.
  - Round-key slice index helper.
- Sub-module aes_round (combinational):
  - Ports: state_in[127:0], round_key[127:0], final_round; output state_out[127:0].
  - Contains SubBytes, ShiftRows, conditional MixColumns and AddRoundKey.
  - The engine holds only the FSM, counter and state register.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f expanded upstream, plaintext 00112233445566778899aabbccddeeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 10 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32.
- Backpressure: out_ready=0 for 5 cycles after out_valid → ciphertext and out_valid stable, in_ready=0 throughout. Release → in_ready=1 next cycle.
- Busy input: in_valid pulsed during ROUND with a different plaintext → ignored; result still matches the first vector.
- Reset mid-round: rst_n low at round 5 → out_valid=0, in_ready=1, ciphertext=0 asynchronously. Next block encrypts correctly.
- AES_ZEROIZE_EN: after output handshake ciphertext reads 00000000000000000000000000000000. Without the macro, the previous ciphertext is retained.
